// File: rtl/mesh_path_allocator_pkg.sv
// Shared constants, route modes and node geometry helpers for the mesh path allocator.
package mesh_alloc_pkg;

    // Bit offset of each router output port inside a node's 5-bit busy group.
    localparam int P_N = 4;
    localparam int P_S = 3;
    localparam int P_E = 2;
    localparam int P_W = 1;
    localparam int P_P = 0;

    typedef enum logic {
        ROUTE_XY = 1'b0,
        ROUTE_YX = 1'b1
    } route_mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } src_state_e;

    function automatic int row_of(int node, int cols);
        return node / cols;
    endfunction

    function automatic int col_of(int node, int cols);
        return node % cols;
    endfunction

endpackage

// File: rtl/mesh_path_allocator_if.sv
// Request/grant bundle between the processing units and the mesh path allocator.
interface mesh_path_allocator_if #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int LEN_W = 8
);
    localparam int N   = ROWS * COLS;
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req_valid;
    logic [N*IDW-1:0]   req_dest;
    logic [N*LEN_W-1:0] req_len;
    logic [N-1:0]       grant;
    logic [N-1:0]       grant_yx;
    logic [N-1:0]       err;
    logic [N-1:0]       active;
    logic [5*N-1:0]     port_busy;

    modport master (
        output req_valid, req_dest, req_len,
        input  grant, grant_yx, err, active, port_busy
    );

    modport slave (
        input  req_valid, req_dest, req_len,
        output grant, grant_yx, err, active, port_busy
    );

endinterface

// File: rtl/mesh_path_allocator_route_mask.sv
// Combinational route walker: set of router output ports a minimal XY or YX route occupies,
// ending with the destination's P port. Out-of-range destinations yield an empty mask.
module mesh_route_mask
    import mesh_alloc_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    localparam int N   = ROWS * COLS,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IDW-1:0] src,
    input  logic [IDW-1:0] dest,
    input  route_mode_e    mode,
    output logic [5*N-1:0] mask
);

    always_comb begin
        int r, c, tr, tc;
        mask = '0;
        r    = row_of(int'(src), COLS);
        c    = col_of(int'(src), COLS);
        tr   = row_of(int'(dest), COLS);
        tc   = col_of(int'(dest), COLS);
        if (int'(dest) < N) begin
            for (int leg = 0; leg < 2; leg++) begin
                // XY walks the horizontal leg first, YX the vertical one.
                if ((leg == 0) == (mode == ROUTE_XY)) begin
                    for (int i = 0; i < COLS; i++) begin
                        if (c < tc) begin
                            mask[5*(r*COLS+c)+P_E] = 1'b1;
                            c = c + 1;
                        end else if (c > tc) begin
                            mask[5*(r*COLS+c)+P_W] = 1'b1;
                            c = c - 1;
                        end
                    end
                end else begin
                    for (int i = 0; i < ROWS; i++) begin
                        if (r < tr) begin
                            mask[5*(r*COLS+c)+P_N] = 1'b1;
                            r = r + 1;
                        end else if (r > tr) begin
                            mask[5*(r*COLS+c)+P_S] = 1'b1;
                            r = r - 1;
                        end
                    end
                end
            end
            mask[5*int'(dest)+P_P] = 1'b1;
        end
    end

endmodule

// File: rtl/mesh_path_allocator.sv
// Round-robin path allocator for a ROWS x COLS mesh; reserves a minimal route per burst.
// Define ALT_PATH_EN to fall back to the YX route when the XY route is busy.
module mesh_path_allocator
    import mesh_alloc_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int LEN_W = 8
) (
    input logic                  clock,
    input logic                  reset,
    mesh_path_allocator_if.slave bus
);

    localparam int N   = ROWS * COLS;
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = 5 * N;
`ifdef ALT_PATH_EN
    localparam bit AltEn = 1'b1;
`else
    localparam bit AltEn = 1'b0;
`endif

    src_state_e       state_q [N];
    logic [LEN_W-1:0] cnt_q   [N];
    logic [PW-1:0]    route_q [N];
    logic [PW-1:0]    busy_q, busy_d;
    logic [IDW-1:0]   rr_q;
    logic [N-1:0]     grant_q, grant_yx_q, err_q;

    logic [PW-1:0]    xy_mask [N];
    logic [PW-1:0]    yx_mask [N];
    logic [N-1:0]     xy_free, yx_free, cand, err_d, releasing;
    logic [N-1:0]     grant_d, grant_yx_d;
    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic [PW-1:0]    pick_mask;
    logic [LEN_W-1:0] pick_len;
    logic [PW-1:0]    release_mask;

    for (genvar g = 0; g < N; g++) begin : g_src
        logic [IDW-1:0] dest;
        logic           idle;

        assign dest = bus.req_dest[g*IDW +: IDW];
        assign idle = (state_q[g] == StIdle);

        mesh_route_mask #(
            .ROWS(ROWS),
            .COLS(COLS)
        ) u_xy (
            .src (IDW'(g)),
            .dest(dest),
            .mode(ROUTE_XY),
            .mask(xy_mask[g])
        );

        mesh_route_mask #(
            .ROWS(ROWS),
            .COLS(COLS)
        ) u_yx (
            .src (IDW'(g)),
            .dest(dest),
            .mode(ROUTE_YX),
            .mask(yx_mask[g])
        );

        assign xy_free[g]   = ~|(xy_mask[g] & busy_q);
        assign yx_free[g]   = ~|(yx_mask[g] & busy_q);
        assign cand[g]      = bus.req_valid[g] && idle && (int'(dest) < N) &&
                              (xy_free[g] || (AltEn && yx_free[g]));
        assign err_d[g]     = bus.req_valid[g] && idle && (int'(dest) >= N);
        assign releasing[g] = (state_q[g] == StHold) && (cnt_q[g] == LEN_W'(1));
    end

    always_comb begin
        pick_valid   = 1'b0;
        pick_idx     = '0;
        pick_mask    = '0;
        pick_len     = '0;
        grant_d      = '0;
        grant_yx_d   = '0;
        release_mask = '0;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (int'(rr_q) + k) % N;
            if (!pick_valid && cand[s]) begin
                pick_valid    = 1'b1;
                pick_idx      = IDW'(s);
                grant_d[s]    = 1'b1;
                // cand only admits a busy XY route when the YX fallback is enabled and free.
                grant_yx_d[s] = !xy_free[s];
                pick_mask     = xy_free[s] ? xy_mask[s] : yx_mask[s];
                pick_len      = bus.req_len[s*LEN_W +: LEN_W];
                if (pick_len == '0) begin
                    pick_len = LEN_W'(1);
                end
            end
        end
        for (int s = 0; s < N; s++) begin
            if (releasing[s]) begin
                release_mask = release_mask | route_q[s];
            end
        end
        busy_d = (busy_q & ~release_mask) | pick_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            grant_yx_q <= '0;
            err_q      <= '0;
            for (int s = 0; s < N; s++) begin
                state_q[s] <= StIdle;
                cnt_q[s]   <= '0;
                route_q[s] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            grant_yx_q <= grant_yx_d;
            err_q      <= err_d;
            if (pick_valid) begin
                rr_q <= (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
            end
            for (int s = 0; s < N; s++) begin
                unique case (state_q[s])
                    StIdle: begin
                        if (grant_d[s]) begin
                            state_q[s] <= StHold;
                            cnt_q[s]   <= pick_len;
                            route_q[s] <= pick_mask;
                        end
                    end
                    StHold: begin
                        cnt_q[s] <= cnt_q[s] - 1'b1;
                        if (releasing[s]) begin
                            state_q[s] <= StIdle;
                            route_q[s] <= '0;
                        end
                    end
                    default: state_q[s] <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        for (int s = 0; s < N; s++) begin
            bus.active[s] = (state_q[s] == StHold);
        end
    end

    assign bus.port_busy = busy_q;
    assign bus.grant     = grant_q;
    assign bus.grant_yx  = grant_yx_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mesh_path_allocator.sv
// Bench for mesh_path_allocator on a 3x3 mesh: directed scenarios plus random traffic against a
// route-walking reference model. Expectations follow ALT_PATH_EN when it is defined.
module tb_mesh_path_allocator;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int LEN_W = 8;
    localparam int N     = ROWS * COLS;
    localparam int IDW   = 4;
    localparam int PW    = 5 * N;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mesh_path_allocator_if #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) bus ();

    mesh_path_allocator #(
        .ROWS (ROWS),
        .COLS (COLS),
        .LEN_W(LEN_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-source remaining burst length and reserved port set.
    logic [PW-1:0] m_busy;
    logic [PW-1:0] m_path [N];
    int            m_left [N];
    int            m_rr;
    logic [N-1:0]  m_grant, m_yx, m_err;

    function automatic logic [PW-1:0] model_route(int src, int dst, bit yx);
        logic [PW-1:0] m;
        int r, c, dr, dc;
        m  = '0;
        r  = src / COLS;
        c  = src % COLS;
        dr = dst / COLS;
        dc = dst % COLS;
        for (int leg = 0; leg < 2; leg++) begin
            if ((leg == 0) != yx) begin
                while (c != dc) begin
                    m[5*(r*COLS+c) + ((c < dc) ? 2 : 1)] = 1'b1;
                    c = (c < dc) ? c + 1 : c - 1;
                end
            end else begin
                while (r != dr) begin
                    m[5*(r*COLS+c) + ((r < dr) ? 4 : 3)] = 1'b1;
                    r = (r < dr) ? r + 1 : r - 1;
                end
            end
        end
        m[5*dst] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] model_active();
        logic [N-1:0] a;
        for (int s = 0; s < N; s++) a[s] = (m_left[s] > 0);
        return a;
    endfunction

    task automatic model_step();
        int pick, d, len;
        bit pyx;
        logic [PW-1:0] pmask, xy, yx;
        m_grant = '0;
        m_yx    = '0;
        m_err   = '0;
        if (reset) begin
            m_busy = '0;
            m_rr   = 0;
            for (int s = 0; s < N; s++) begin
                m_left[s] = 0;
                m_path[s] = '0;
            end
            return;
        end
        pick  = -1;
        pyx   = 1'b0;
        pmask = '0;
        xy    = '0;
        yx    = '0;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_rr + k) % N;
            d = int'(bus.req_dest[s*IDW +: IDW]);
            if (bus.req_valid[s] && m_left[s] == 0) begin
                if (d >= N) begin
                    m_err[s] = 1'b1;
                end else if (pick < 0) begin
                    xy = model_route(s, d, 1'b0);
                    if ((xy & m_busy) == '0) begin
                        pick  = s;
                        pmask = xy;
                    end
`ifdef ALT_PATH_EN
                    else begin
                        yx = model_route(s, d, 1'b1);
                        if ((yx & m_busy) == '0) begin
                            pick  = s;
                            pmask = yx;
                            pyx   = 1'b1;
                        end
                    end
`endif
                end
            end
        end
        for (int s = 0; s < N; s++) begin
            if (m_left[s] > 0) begin
                if (m_left[s] == 1) m_busy = m_busy & ~m_path[s];
                m_left[s] = m_left[s] - 1;
            end
        end
        if (pick >= 0) begin
            len            = int'(bus.req_len[pick*LEN_W +: LEN_W]);
            m_busy         = m_busy | pmask;
            m_path[pick]   = pmask;
            m_left[pick]   = (len == 0) ? 1 : len;
            m_grant[pick]  = 1'b1;
            m_yx[pick]     = pyx;
            m_rr           = (pick + 1) % N;
        end
    endtask

    // Advance one clock; a source drops its request once it is granted or rejected.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        for (int s = 0; s < N; s++) begin
            if (m_grant[s] || m_err[s]) bus.req_valid[s] = 1'b0;
        end
    endtask

    task automatic set_req(input int s, input int d, input int len);
        bus.req_valid[s]               = 1'b1;
        bus.req_dest[s*IDW +: IDW]     = IDW'(d);
        bus.req_len[s*LEN_W +: LEN_W]  = LEN_W'(len);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_dest  = '0;
        bus.req_len   = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.port_busy !== '0) begin
            n_bad++;
            $display("FAIL reset_port_busy got %h want 0", bus.port_busy);
        end
        n_cmp++;
        if (bus.active !== '0) begin
            n_bad++;
            $display("FAIL reset_active got %h want 0", bus.active);
        end
        n_cmp++;
        if ({bus.grant, bus.grant_yx, bus.err} !== '0) begin
            n_bad++;
            $display("FAIL reset_pulses got %h/%h/%h want 0", bus.grant, bus.grant_yx, bus.err);
        end
    endtask

    task automatic test_single_route();
        logic [PW-1:0] exp;
        exp     = '0;
        exp[2]  = 1'b1;  // node0.E
        exp[9]  = 1'b1;  // node1.N
        exp[20] = 1'b1;  // node4.P
        do_reset();
        set_req(0, 4, 4);
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (bus.port_busy !== ((c <= 4) ? exp : PW'(0))) begin
                n_bad++;
                $display("FAIL single_busy cyc %0d got %h want %h", c, bus.port_busy,
                         (c <= 4) ? exp : PW'(0));
            end
            n_cmp++;
            if (bus.grant !== ((c == 1) ? 9'h001 : 9'h000) || bus.grant_yx !== 9'h000) begin
                n_bad++;
                $display("FAIL single_grant cyc %0d got %h/%h", c, bus.grant, bus.grant_yx);
            end
            n_cmp++;
            if (bus.active !== ((c <= 4) ? 9'h001 : 9'h000)) begin
                n_bad++;
                $display("FAIL single_active cyc %0d got %h", c, bus.active);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq [4] = '{0, 1, 3, 4};
        do_reset();
        set_req(0, 1, 2);
        set_req(1, 0, 2);
        set_req(3, 4, 2);
        set_req(4, 3, 2);
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (bus.grant !== (9'h001 << seq[c])) begin
                n_bad++;
                $display("FAIL rr_order step %0d got %h want %h", c, bus.grant,
                         9'h001 << seq[c]);
            end
        end
    endtask

    task automatic test_alt_path();
        int k, exp_k;
        logic got_yx, exp_yx;
        logic [PW-1:0] got_busy, exp_busy;
        exp_busy = '0;
`ifdef ALT_PATH_EN
        exp_k  = 1;
        exp_yx = 1'b1;
        exp_busy[7]  = 1'b1;  // node1.E (1->2 still held)
        exp_busy[10] = 1'b1;  // node2.P
        exp_busy[4]  = 1'b1;  // node0.N
        exp_busy[17] = 1'b1;  // node3.E
        exp_busy[22] = 1'b1;  // node4.E
        exp_busy[25] = 1'b1;  // node5.P
`else
        exp_k  = 11;
        exp_yx = 1'b0;
        exp_busy[2]  = 1'b1;  // node0.E
        exp_busy[7]  = 1'b1;  // node1.E
        exp_busy[14] = 1'b1;  // node2.N
        exp_busy[25] = 1'b1;  // node5.P
`endif
        do_reset();
        set_req(1, 2, 10);
        tick();
        set_req(0, 5, 4);
        k        = 0;
        got_yx   = 1'bx;
        got_busy = 'x;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            tick();
            if (bus.grant[0] === 1'b1) begin
                k        = i;
                got_yx   = bus.grant_yx[0];
                got_busy = bus.port_busy;
            end
        end
        n_cmp++;
        if (k != exp_k) begin
            n_bad++;
            $display("FAIL alt_grant_delay got %0d want %0d (0 = never)", k, exp_k);
        end
        n_cmp++;
        if (got_yx !== exp_yx) begin
            n_bad++;
            $display("FAIL alt_grant_yx got %b want %b", got_yx, exp_yx);
        end
        n_cmp++;
        if (got_busy !== exp_busy) begin
            n_bad++;
            $display("FAIL alt_busy got %h want %h", got_busy, exp_busy);
        end
    endtask

    task automatic test_len_zero_and_err();
        logic [PW-1:0] exp;
        exp    = '0;
        exp[5] = 1'b1;  // node1.P only
        do_reset();
        set_req(1, 1, 0);
        set_req(0, 12, 3);
        tick();
        n_cmp++;
        if (bus.grant !== 9'h002 || bus.err !== 9'h001) begin
            n_bad++;
            $display("FAIL len0_err_pulse grant %h err %h want 002/001", bus.grant, bus.err);
        end
        n_cmp++;
        if (bus.port_busy !== exp || bus.active !== 9'h002) begin
            n_bad++;
            $display("FAIL len0_busy got %h act %h want %h/002", bus.port_busy, bus.active, exp);
        end
        tick();
        n_cmp++;
        if ({bus.port_busy, bus.active, bus.grant, bus.err} !== '0) begin
            n_bad++;
            $display("FAIL len0_release busy %h act %h grant %h err %h", bus.port_busy,
                     bus.active, bus.grant, bus.err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(4, 8, 20);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.port_busy !== '0 || bus.active !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear busy %h act %h want 0", bus.port_busy, bus.active);
        end
        // Round-robin pointer must be back at 0: source 0 beats source 6.
        set_req(0, 1, 3);
        set_req(6, 7, 3);
        tick();
        n_cmp++;
        if (bus.grant !== 9'h001) begin
            n_bad++;
            $display("FAIL midreset_first got %h want 001", bus.grant);
        end
        tick();
        n_cmp++;
        if (bus.grant !== 9'h040) begin
            n_bad++;
            $display("FAIL midreset_second got %h want 040", bus.grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < N; s++) begin
                if (!bus.req_valid[s] && $urandom_range(0, 3) == 0) begin
                    set_req(s, ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15)
                                                           : $urandom_range(0, 8),
                            $urandom_range(0, 6));
                end
            end
            tick();
            n_cmp++;
            if (bus.grant !== m_grant || bus.grant_yx !== m_yx || bus.err !== m_err) begin
                n_bad++;
                $display("FAIL rand_pulses cyc %0d got %h/%h/%h want %h/%h/%h", c, bus.grant,
                         bus.grant_yx, bus.err, m_grant, m_yx, m_err);
            end
            n_cmp++;
            if (bus.port_busy !== m_busy || bus.active !== model_active()) begin
                n_bad++;
                $display("FAIL rand_state cyc %0d busy %h act %h want %h/%h", c, bus.port_busy,
                         bus.active, m_busy, model_active());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_round_robin();
        test_alt_path();
        test_len_zero_and_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mesh_path_allocator.md
# mesh_path_allocator

Parametrised path allocator for a ROWS x COLS mesh of routers and processing units, successor to the fixed 2x2 path-availability logic. Tracks every router output port as a reservable resource, arbitrates transfer requests from all processors round-robin, selects a free minimal route (XY, optionally YX), and holds that route reserved for the burst length before releasing it automatically. Sits between the processing units and the master/router control logic.

## Interface
- ROWS, 2, mesh rows; row 0 is the bottom row, so north means row+1.
- COLS, 2, mesh columns; node index = row*COLS + col.
- LEN_W, 8, burst length width.
- N (localparam), ROWS*COLS, node count; IDW = max(1, clog2(N)).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  N  per-source request; held until grant or err.
- req_dest  in  N*IDW  destination per source; slice s = [s*IDW +: IDW].
- req_len  in  N*LEN_W  burst length per source; 0 is treated as 1.
- grant  out  N  one-cycle grant pulse per source.
- grant_yx  out  N  valid with grant; 1 = YX route, 0 = XY route.
- err  out  N  one-cycle pulse when the request has req_dest >= N.
- active  out  N  source currently holds a reservation.
- port_busy  out  5*N  busy per router output; node n bits [5n+4:5n] = N,S,E,W,P. This order matches the router SetNR..SetPR ordering.

## Operation
- Resource model: a route is the set of output ports it traverses plus the P port of the destination.
  - XY route: move along E/W until the column matches, then along N/S, then P.
  - YX route: move along Y first, then X, then P.
  - Self-transfer (dest == src) reserves only the source's P port.
- Eligible sources: req_valid=1, active=0 and dest < N. A request with dest >= N produces an err pulse and no grant.
- Free test: a route is free when none of its ports are set in the registered port_busy.
  - The XY route is tried first.
  - The YX route is tried only with ALT_PATH_EN.
- Arbitration: among eligible sources with a free route, choose the first one at or after rr_ptr, scanning circularly.
  - At most one grant per cycle.
  - rr_ptr resets to 0. After a grant to source s it becomes (s+1) mod N; otherwise it is unchanged.
- On grant to s:
  - OR the route mask into port_busy.
  - Store the mask in route[s].
  - Load cnt[s] = max(req_len,1) and set active[s].
- Per active source, cnt[s] decrements every cycle. At the edge where cnt[s]==1:
  - Clear route[s] from port_busy.
  - Clear active[s].
- Sources that lose arbitration or are blocked keep waiting; there is no timeout.
- Simultaneous release and new grant in the same cycle: the free test uses the pre-edge port_busy, so freed ports become grantable one cycle later.
- Simultaneous err and grant to different sources: both pulses are allowed in the same cycle.
- Per-source state machine: IDLE -> (grant) -> HOLD -> (cnt==1) -> IDLE. HOLD ignores req_valid.
- Reset mid-operation: all reservations are dropped at once. port_busy, active, grant, grant_yx, err, cnt, route and rr_ptr all go to 0.

## Timing
- grant, grant_yx and err are registered. A request evaluated in cycle t pulses in cycle t+1.
- port_busy and active are set from t+1 and stay set for exactly len cycles (t+1 .. t+len). Ports are free from t+len+1.
- The earliest re-grant of those ports pulses at t+len+2.
- A source must deassert req_valid in the cycle it sees grant. A held request is re-granted after release.
- Reset values of all outputs are 0.

## Configuration
- ALT_PATH_EN defined: when the XY route is busy, the YX route is tried, and grant_yx reports which route was used.
- ALT_PATH_EN undefined: XY only, and grant_yx is tied to 0.

## Structure
- mesh_alloc_pkg holds:
  - port index constants P_N=4, P_S=3, P_E=2, P_W=1, P_P=0;
  - the route-mode constants ROUTE_XY and ROUTE_YX;
  - the node row/col helper functions.
- Sub-module mesh_route_mask: combinational; (src, dest, mode) -> 5*N port mask. Instantiated twice per source (XY and YX).

## Test plan
- 2x2, P0 dest 3, len 4 -> grant[0] and grant_yx=0 at t+1. port_busy bits node0.E, node1.N and node3.P are set for cycles t+1..t+4 and clear at t+5.
- 2x2, P0->1, P1->0, P2->3, P3->2 all asserted in the same cycle, len 2 -> grants pulse one per cycle in order 0, 1, 2, 3 (cycles t+1..t+4).
- 3x3 with ALT_PATH_EN, 1->2 active with len 10, then 0->5 requested -> XY conflicts on node1.E. YX is granted with grant_yx=1, reserving node0.N, node3.E, node4.E and node5.P.
- Same stimulus with ALT_PATH_EN undefined -> 0->5 waits. It is granted XY at the cycle after node1.E is released.
- 2x2, P1 dest 1, len 0 -> grant[1] at t+1. Only node1.P is busy, for 1 cycle. Separately, P0 dest 4 -> err[0] at t+1, with no grant and no busy bits.
- Reset asserted during a len 20 hold -> the cycle after reset, port_busy, active and rr_ptr are 0. A new request is granted normally after reset drops.
